// File: rtl/iterative_alu_unit.sv
// Iterative ALU: one-cycle logic/arith ops; shifts run one bit per cycle through a serial shifter.
// Define ALU_BARREL_SHIFT_EN to do shifts in a single cycle (SHIFT state then unreachable).
module iterative_alu_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero
);
  localparam int SH_W = $clog2(DATA_W);

  // Opcode encoding shared with the ALU control decoder.
  localparam logic [3:0] ALU_ADD  = 4'd0,  ALU_SUB = 4'd1, ALU_AND = 4'd2,
                         ALU_OR   = 4'd3,  ALU_XOR = 4'd4, ALU_SLL = 4'd5,
                         ALU_SRL  = 4'd6,  ALU_SRA = 4'd7, ALU_SLT = 4'd8,
                         ALU_SLTU = 4'd9,  ALU_PASS = 4'd10;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  logic [SH_W-1:0] shamt;
  logic            accept, go_shift;
  assign shamt  = b[SH_W-1:0];
  assign accept = in_valid && in_ready;

  function automatic logic [DATA_W-1:0] alu_comb(input logic [3:0] op,
                                                 input logic [DATA_W-1:0] x, y);
    logic [SH_W-1:0] s;
    s = y[SH_W-1:0];
    case (op)
      ALU_ADD:  return x + y;
      ALU_SUB:  return x - y;
      ALU_AND:  return x & y;
      ALU_OR:   return x | y;
      ALU_XOR:  return x ^ y;
      ALU_SLL:  return x << s;
      ALU_SRL:  return x >> s;
      ALU_SRA:  return $signed(x) >>> s;
      ALU_SLT:  return {{(DATA_W-1){1'b0}}, $signed(x) < $signed(y)};
      ALU_SLTU: return {{(DATA_W-1){1'b0}}, x < y};
      default:  return y;  // PASS and any undefined code
    endcase
  endfunction

`ifdef ALU_BARREL_SHIFT_EN
  assign go_shift = 1'b0;
`else
  logic [DATA_W-1:0] acc, acc_sh;
  logic [SH_W-1:0]   cnt;
  logic [3:0]        op_q;

  // shamt==0 skips the serial path; alu_comb then simply returns a.
  assign go_shift = (alu_op == ALU_SLL || alu_op == ALU_SRL || alu_op == ALU_SRA)
                    && (shamt != '0);

  always_comb begin
    acc_sh = acc;
    case (op_q)
      ALU_SLL: acc_sh = {acc[DATA_W-2:0], 1'b0};
      ALU_SRL: acc_sh = {1'b0, acc[DATA_W-1:1]};
      default: acc_sh = {acc[DATA_W-1], acc[DATA_W-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc  <= '0;
      cnt  <= '0;
      op_q <= ALU_ADD;
    end else if (accept && go_shift) begin
      acc  <= a;
      cnt  <= shamt;
      op_q <= alu_op;
    end else if (state == SHIFT) begin
      acc  <= acc_sh;
      cnt  <= cnt - SH_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = go_shift ? SHIFT : DONE;
`ifdef ALU_BARREL_SHIFT_EN
      SHIFT: state_nxt = IDLE;
`else
      SHIFT: if (cnt == SH_W'(1)) state_nxt = DONE;
`endif
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Result only moves on accept or the final shift step, so it is stable through DONE.
  always_ff @(posedge clk) begin
    if (!rst)
      result <= '0;
    else if (accept && !go_shift)
      result <= alu_comb(alu_op, a, b);
`ifndef ALU_BARREL_SHIFT_EN
    else if (state == SHIFT && cnt == SH_W'(1))
      result <= acc_sh;
`endif
  end

  assign zero = (result == '0);
endmodule

// File: tb/tb_iterative_alu_unit.sv
// Directed-vector bench for iterative_alu_unit (serial-shift build) with immediate assertions.
module tb_iterative_alu_unit;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                         SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9,
                         PASS = 4'd10, UNDEF = 4'd15;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, zero;
  logic [3:0]  alu_op;
  logic [31:0] a, b, result;
  int          n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  iterative_alu_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for out_valid, check latency/result, hold for `hold` cycles, then drain.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input int exp_lat, input logic [31:0] exp_res,
                        input int hold);
    int lat;
    chk({tag, ".in_ready_idle"}, {31'b0, in_ready}, 32'd1);
    alu_op = op; a = av; b = bv; in_valid = 1'b1;
    step();
    // Scramble inputs and keep in_valid high: none of it may disturb the op in flight.
    alu_op = PASS; a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".result"},  result, exp_res);
    chk({tag, ".zero"},    {31'b0, zero}, {31'b0, exp_res == 32'd0});
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, ".hold_result"}, result, exp_res);
      chk({tag, ".hold_in_ready"}, {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".drained"}, {30'b0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    bit seen;
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    alu_op = ADD; a = 32'd5; b = 32'd7;
    step(); step();
    chk("reset.out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset.in_ready",  {31'b0, in_ready},  32'd1);
    chk("reset.result",    result, 32'd0);
    chk("reset.zero",      {31'b0, zero}, 32'd1);
    in_valid = 1'b0; rst = 1'b1;
    step();

    run_op("add",   ADD,  32'd5,        32'd7,  1, 32'd12, 0);
    run_op("sub",   SUB,  32'd3,        32'd3,  1, 32'd0,  0);
    run_op("slt",   SLT,  32'hFFFFFFFF, 32'd1,  1, 32'd1,  0);
    run_op("sltu",  SLTU, 32'hFFFFFFFF, 32'd1,  1, 32'd0,  0);
    run_op("and",   AND_, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 32'h00F0_1200, 0);
    run_op("or",    OR_,  32'hF000_0001, 32'h0000_0F00, 1, 32'hF000_0F01, 0);
    run_op("xor",   XOR_, 32'hAAAA_5555, 32'hFFFF_0000, 1, 32'h5555_5555, 0);
    run_op("sra31", SRA,  32'h80000000, 32'd31, 32, 32'hFFFFFFFF, 0);
    run_op("srl31", SRL,  32'h80000000, 32'd31, 32, 32'h00000001, 0);
    run_op("sll_hi", SLL, 32'd1,        32'h21, 2, 32'd2, 0);
    run_op("sra_pos", SRA, 32'h4000_0000, 32'd4, 5, 32'h0400_0000, 0);
    run_op("sll0",  SLL,  32'hA5,       32'd0,  1, 32'hA5, 0);
    run_op("pass",  PASS, 32'hDEAD,     32'h1234, 1, 32'h1234, 0);
    run_op("undef", UNDEF, 32'hDEAD,    32'h55, 1, 32'h55, 0);
    run_op("bp_add", ADD, 32'd1,        32'd2,  1, 32'd3, 5);
    run_op("after_bp", ADD, 32'd10,     32'd20, 1, 32'd30, 0);

    // Reset while an SRL by 20 is in progress.
    alu_op = SRL; a = 32'hFFFF0000; b = 32'd20; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("midrst.busy", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst.in_ready",  {31'b0, in_ready},  32'd1);
    chk("midrst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst.result",    result, 32'd0);
    seen = 1'b0;
    repeat (25) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("midrst.no_result", {31'b0, seen}, 32'd0);
    run_op("post_rst_add", ADD, 32'd1, 32'd1, 1, 32'd2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/iterative_alu_unit.md
Name: iterative_alu_unit

Overview:
- Execution-side consumer of the 4-bit ALU operation code produced by the ALU control decoder.
- Accepts an operation code and two operands over a valid/ready handshake, then executes it.
- Non-shift operations complete in one cycle; shifts run one bit per cycle, so a compact serial shifter replaces a barrel shifter.
- Sits between the decode/operand stage and writeback for the multi-cycle core variant.

Parameters:
- DATA_W, 32, operand/result width; shift amount taken from b[$clog2(DATA_W)-1:0]

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
- in_valid  in  1  operation/operands valid
- in_ready  out  1  unit can accept an operation
- alu_op  in  4  ALU operation code from defines.v (`ALU_ADD, `ALU_SUB, `ALU_AND, `ALU_OR, `ALU_XOR, `ALU_SLL, `ALU_SRL, `ALU_SRA, `ALU_SLT, `ALU_SLTU, `ALU_PASS)
- a  in  DATA_W  operand A (rs1)
- b  in  DATA_W  operand B (rs2 or immediate)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  DATA_W  operation result
- zero  out  1  result == 0

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE.
  - in_ready=1, out_valid=0, result=0, zero=1.
  - Reset mid-operation abandons the operation; no result is ever presented for it.
- States and transitions:
  - IDLE: in_ready=1. The operation is accepted when in_valid && in_ready. On accept, alu_op, a and b[shamt] are latched.
    - Non-shift op: compute result -> DONE.
    - Shift op with shamt==0: result=a -> DONE.
    - Shift op with shamt>0: acc=a, cnt=shamt -> SHIFT.
  - SHIFT: in_ready=0, out_valid=0. Each cycle, acc shifts by 1 and cnt decrements.
    - SLL: zero fill.
    - SRL: zero fill.
    - SRA: fills with acc MSB.
    - When cnt becomes 0: result=acc -> DONE.
  - DONE: out_valid=1, in_ready=0. result and zero are held stable until out_ready==1, then -> IDLE.
- Latency: accept at cycle N -> out_valid at N+1 for non-shift ops, N+1+shamt for shifts. Max throughput is one op per 2 cycles.
- Arithmetic:
  - ADD/SUB: modulo 2^DATA_W; no carry out.
  - SLT: signed compare. SLTU: unsigned compare. Both give result {0..0,1} or 0.
  - PASS: result=b.
  - Any undefined code: treated as PASS, matching the decoder's error default.
- Boundaries:
  - shamt uses only the low bits of b; upper bits are ignored. Example: b=32'h21 gives shamt 1.
  - SRA of a negative value by DATA_W-1 yields all ones.
  - in_valid asserted outside IDLE is ignored and not queued. Upstream must hold in_valid until in_ready.
  - out_ready high while not in DONE has no effect.
  - alu_op/a/b changing during SHIFT or DONE do not affect the result.

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN
- Defined:
  - Shifts complete in one cycle like other ops: accept at N -> out_valid at N+1; SHIFT state unused.
  - Results are identical to the serial mode.
- Undefined: serial one-bit-per-cycle shifting as described above.

Test Plan:
- Reset: hold rst=0 for 2 cycles while in_valid=1 -> out_valid=0, in_ready=1, result=0, zero=1. Release, then ADD a=5 b=7 -> out_valid exactly 1 cycle after accept, result=12, zero=0.
- SUB/compare:
  - SUB a=3 b=3 -> result=0, zero=1.
  - SLT a=32'hFFFFFFFF b=1 -> result=1.
  - SLTU with the same operands -> result=0.
- Serial shifts (macro off):
  - SRA a=32'h80000000 b=31 -> out_valid 32 cycles after accept, result=32'hFFFFFFFF.
  - SRL with the same operands -> result=32'h00000001.
  - SLL a=1 b=32'h21 -> result=2 after 2 cycles.
- Zero shift and PASS:
  - SLL a=32'hA5 b=0 -> result=32'hA5, latency 1.
  - PASS b=32'h1234 -> result=32'h1234.
  - Undefined code -> behaves as PASS.
- Backpressure: out_ready=0 for 5 cycles after ADD a=1 b=2 -> result=3 held stable and in_ready=0 throughout. Pulse out_ready -> IDLE next cycle; a new op is accepted the cycle after.
- Reset mid-shift: start SRL shamt=20 and assert rst=0 at cycle 5 -> next cycle IDLE, out_valid never asserts for that op. A following ADD 1+1 returns 2.
